// File: rtl/fifo_buffer.sv
// Single-clock valid/ready FIFO over one iCE40-style dual-port block RAM, first-word-fall-through output.
// Optional macro FIFO_LEVEL_EN adds a registered `level` port (words held, RAM plus output slot).

module dual_port_memory #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  rclk,
  input  logic                  rclke,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata,
  input  logic                  wclk,
  input  logic                  wclke,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata
);
  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  // NOTE: neither the array nor the read register is reset; block RAM has no reset,
  // so anything that must look clean after reset is masked downstream.
  always_ff @(posedge wclk) begin
    if (wclke && we) mem[waddr] <= wdata;
  end

  always_ff @(posedge rclk) begin
    if (rclke && re) rdata <= mem[raddr];
  end
endmodule

module fifo_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 512
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0] level
`endif
);
  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr, wr_ptr_next;
  logic [ADDR_WIDTH-1:0] rd_ptr, rd_ptr_next;
  logic [ADDR_WIDTH:0]   ram_count, ram_count_next;
  logic                  out_valid_next;
  logic [WIDTH-1:0]      ram_rdata;
  logic                  push, pop, fetch;

  // in_ready depends on registered count only, so out_ready never reaches it combinationally.
  assign in_ready = (ram_count != FULL_COUNT);
  assign push     = in_valid && in_ready && !flush;
  assign pop      = out_valid && out_ready;
  // The word written this cycle is not yet counted, so a fetch never hits the write address.
  assign fetch    = (ram_count != '0) && (!out_valid || out_ready) && !flush;
  assign out_data = out_valid ? ram_rdata : '0;

  // NOTE: next-state logic is pure combinational with defaults first (no latches);
  // only the always_ff below holds state, using non-blocking assignments.
  always_comb begin
    wr_ptr_next    = wr_ptr;
    rd_ptr_next    = rd_ptr;
    ram_count_next = ram_count;
    out_valid_next = out_valid;
    if (flush) begin
      wr_ptr_next    = '0;
      rd_ptr_next    = '0;
      ram_count_next = '0;
      out_valid_next = 1'b0;
    end else begin
      if (push)  wr_ptr_next = wr_ptr + ADDR_WIDTH'(1);
      if (fetch) rd_ptr_next = rd_ptr + ADDR_WIDTH'(1);
      case ({push, fetch})
        2'b10:   ram_count_next = ram_count + 1'b1;
        2'b01:   ram_count_next = ram_count - 1'b1;
        default: ram_count_next = ram_count;
      endcase
      if (fetch)    out_valid_next = 1'b1;
      else if (pop) out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_count <= '0;
      out_valid <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr_next;
      rd_ptr    <= rd_ptr_next;
      ram_count <= ram_count_next;
      out_valid <= out_valid_next;
    end
  end

`ifdef FIFO_LEVEL_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) level <= '0;
    else          level <= ram_count_next + {{ADDR_WIDTH{1'b0}}, out_valid_next};
  end
`endif

  dual_port_memory #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .rclk  (clock),
    .rclke (1'b1),
    .re    (fetch),
    .raddr (rd_ptr),
    .rdata (ram_rdata),
    .wclk  (clock),
    .wclke (1'b1),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_data)
  );
endmodule

// File: tb/tb_fifo_buffer.sv
// Directed self-checking bench for fifo_buffer at DEPTH=4: reset, latency, full, stall,
// wrap with a handshake scoreboard, flush, and asynchronous reset mid-stream.

module tb_fifo_buffer;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef FIFO_LEVEL_EN
  logic [$clog2(DEPTH):0] level;
`endif

  int checks = 0;
  int passes = 0;

  fifo_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef FIFO_LEVEL_EN
    ,
    .level     (level)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] q[$];
    int sent, recv;
    logic push_hs, pop_hs;

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    step(); step();
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_data", out_data, 0);
`ifdef FIFO_LEVEL_EN
    check("reset_level", level, 0);
`endif
    reset_n = 1'b1;
    step();

    // Latency: 0xA5 into an empty FIFO appears on the second edge after it is offered.
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    step();
    in_valid = 1'b0; in_data = '0;
    check("lat_edge1_valid", out_valid, 0);
    step();
    check("lat_edge2_valid", out_valid, 1);
    check("lat_edge2_data", out_data, 8'hA5);
    step();
    check("lat_after_pop_valid", out_valid, 0);
    check("lat_after_pop_data", out_data, 0);

    // Full: six words offered with out_ready low, five fit (4 in RAM + output slot).
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      step();
      check($sformatf("full_in_ready_%0d", i), in_ready, (i < 4) ? 1 : 0);
    end
    in_valid = 1'b0;
`ifdef FIFO_LEVEL_EN
    check("full_level", level, 5);
`endif
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("full_drain_valid_%0d", k), out_valid, 1);
      check($sformatf("full_drain_data_%0d", k), out_data, k);
      step();
    end
    check("full_drained_valid", out_valid, 0);
    check("full_drained_in_ready", in_ready, 1);
    out_ready = 1'b0;

    // Stall: output held for ten cycles while three more words queue behind it.
    in_valid = 1'b1; in_data = 8'h11;
    step();
    in_valid = 1'b0;
    step();
    q.push_back(8'h11);
    for (int c = 0; c < 10; c++) begin
      if (c < 3) begin
        in_valid = 1'b1; in_data = 8'(8'h20 + c); q.push_back(8'(8'h20 + c));
      end else begin
        in_valid = 1'b0;
      end
      check("stall_valid", out_valid, 1);
      check("stall_hold_data", out_data, 8'h11);
      step();
    end
    check("stall_end_data", out_data, 8'h11);
    // Release with continuous push: one word out every cycle, order kept.
    for (int c = 0; c < 8; c++) begin
      out_ready = 1'b1; in_valid = 1'b1; in_data = 8'(8'h30 + c);
      check("stream_valid", out_valid, 1);
      check("stream_data", out_data, q[0]);
      step();
      void'(q.pop_front());
      q.push_back(8'(8'h30 + c));
    end
    in_valid = 1'b0;
    for (int n = 0; n < 20 && q.size() != 0; n++) begin
      check("stream_drain_valid", out_valid, 1);
      check("stream_drain_data", out_data, q[0]);
      void'(q.pop_front());
      step();
    end
    check("stream_drain_done", q.size(), 0);
    check("stream_empty_valid", out_valid, 0);

    // Wrap: 20 words with random handshakes, scored at the observed handshakes.
    sent = 0; recv = 0;
    for (int n = 0; n < 400 && recv < 20; n++) begin
      in_valid  = (sent < 20) && ($urandom_range(0, 3) != 0);
      in_data   = 8'(8'h40 + sent);
      out_ready = ($urandom_range(0, 3) != 0);
      push_hs = in_valid && in_ready;
      pop_hs  = out_valid && out_ready;
      if (pop_hs) begin
        if (q.size() == 0) begin
          check("wrap_pop_when_empty", out_valid, 0);
        end else begin
          check("wrap_data", out_data, q[0]);
          void'(q.pop_front());
        end
        recv++;
      end
      if (push_hs) begin
        q.push_back(in_data);
        sent++;
      end
      check("wrap_occupancy_le_5", (q.size() <= DEPTH + 1) ? 1 : 0, 1);
      step();
    end
    check("wrap_received", recv, 20);
    in_valid = 1'b0; out_ready = 1'b0;
    step();

    // Flush: three words held, flush with in_valid high clears everything.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h31 + i);
      step();
    end
    in_valid = 1'b0;
    step();
    check("preflush_valid", out_valid, 1);
    check("preflush_data", out_data, 8'h31);
`ifdef FIFO_LEVEL_EN
    check("preflush_level", level, 3);
`endif
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    check("flush_data", out_data, 0);
`ifdef FIFO_LEVEL_EN
    check("flush_level", level, 0);
`endif
    step(); step();
    check("flush_nothing_stored", out_valid, 0);
    in_valid = 1'b1; in_data = 8'h55;
    step();
    in_valid = 1'b0;
    step();
    check("postflush_valid", out_valid, 1);
    check("postflush_data", out_data, 8'h55);
    step();

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h61;
    step();
    in_data = 8'h62;
    step();
    in_valid = 1'b0;
    step();
    check("prereset_data", out_data, 8'h61);
    reset_n = 1'b0;
    #1;
    check("async_reset_valid", out_valid, 0);
    check("async_reset_in_ready", in_ready, 1);
    check("async_reset_data", out_data, 0);
`ifdef FIFO_LEVEL_EN
    check("async_reset_level", level, 0);
`endif
    step();
    reset_n = 1'b1;
    out_ready = 1'b1;
    step(); step();
    check("reset_discarded_valid", out_valid, 0);
    check("reset_discarded_in_ready", in_ready, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
